// File: rtl/ra_list_walker.sv
// ra_list_walker: walks the PVR region array in VRAM one word per read,
// assembles each v1 (5-word) or v2 (6-word) entry, and hands it to the tile
// scheduler over valid/ready. The walk stops on an entry with LAST set, or
// when the entry guard is reached, which raises a sticky error.
module ra_list_walker #(
  parameter int ADDR_W      = 24,
  parameter int MAX_ENTRIES = 1200,
  parameter int CNT_W       = 11
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ra_trig,
  input  logic [ADDR_W-1:0] region_base,
  input  logic              fmt_v2,
  output logic              ra_vram_rd,
  output logic [ADDR_W-1:0] ra_vram_addr,
  input  logic [31:0]       ra_vram_din,
  input  logic              ra_vram_dvalid,
  output logic [31:0]       ra_control,
  output logic [31:0]       ra_opaque,
  output logic [31:0]       ra_opaque_mod,
  output logic [31:0]       ra_trans,
  output logic [31:0]       ra_trans_mod,
  output logic [31:0]       ra_puncht,
  output logic              ra_cont_last,
  output logic              ra_cont_zclear,
  output logic              ra_cont_flush,
  output logic [5:0]        ra_cont_tiley,
  output logic [5:0]        ra_cont_tilex,
  output logic              ra_entry_valid,
  input  logic              ra_entry_ready,
  output logic [CNT_W-1:0]  ra_entry_idx,
  output logic              ra_busy,
  output logic              ra_done,
  output logic              ra_err
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_EMIT, S_FIN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic              fmt;
  logic [2:0]        widx;
  logic              trig_ok, word_in, last_word, accept, at_guard;

  assign trig_ok   = (state == S_IDLE) && ra_trig;
  assign word_in   = (state == S_WAIT) && ra_vram_dvalid;
  assign last_word = (widx == (fmt ? 3'd5 : 3'd4));
  assign accept    = (state == S_EMIT) && ra_entry_ready;
  assign at_guard  = (ra_entry_idx == CNT_W'(MAX_ENTRIES - 1));

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; one read outstanding at a time, REQ always lasts one cycle
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (ra_trig) state_nxt = S_REQ;
      S_REQ:  state_nxt = S_WAIT;
      S_WAIT: if (ra_vram_dvalid) state_nxt = last_word ? S_EMIT : S_REQ;
      S_EMIT: if (ra_entry_ready) state_nxt = (ra_cont_last || at_guard) ? S_FIN : S_REQ;
      S_FIN:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded straight from state
  always_comb begin
    ra_vram_rd     = 1'b0;
    ra_entry_valid = 1'b0;
    ra_done        = 1'b0;
    ra_busy        = 1'b1;
    case (state)
      S_IDLE: ra_busy        = 1'b0;
      S_REQ:  ra_vram_rd     = 1'b1;
      S_EMIT: ra_entry_valid = 1'b1;
      S_FIN:  ra_done        = 1'b1;
      default: ;
    endcase
  end

  // Walk datapath: pointer, word/entry indices, entry words, sticky error.
  // Entry words only load in WAIT, so they are frozen while valid is high.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr           <= '0;
      fmt           <= 1'b0;
      widx          <= '0;
      ra_entry_idx  <= '0;
      ra_err        <= 1'b0;
      ra_control    <= '0;
      ra_opaque     <= '0;
      ra_opaque_mod <= '0;
      ra_trans      <= '0;
      ra_trans_mod  <= '0;
      ra_puncht     <= '0;
    end else begin
      if (trig_ok) begin
        ptr          <= region_base & ~ADDR_W'(3);
        fmt          <= fmt_v2;
        widx         <= '0;
        ra_entry_idx <= '0;
        ra_err       <= 1'b0;
      end
      if (word_in) begin
        case (widx)
          3'd0: ra_control    <= ra_vram_din;
          3'd1: ra_opaque     <= ra_vram_din;
          3'd2: ra_opaque_mod <= ra_vram_din;
          3'd3: ra_trans      <= ra_vram_din;
          3'd4: ra_trans_mod  <= ra_vram_din;
          default: ra_puncht  <= ra_vram_din;
        endcase
        // v1 entries carry no punch-through word; use the fixed default
        if (widx == 3'd4 && !fmt) ra_puncht <= 32'h8000_0000;
        ptr <= ptr + ADDR_W'(4);
        if (!last_word) widx <= widx + 3'd1;
      end
      if (accept && !ra_cont_last) begin
        if (at_guard) ra_err <= 1'b1;
        else begin
          ra_entry_idx <= ra_entry_idx + CNT_W'(1);
          widx         <= '0;
        end
      end
    end
  end

  assign ra_vram_addr   = ptr;
  assign ra_cont_last   = ra_control[31];
  assign ra_cont_zclear = ra_control[30];
  assign ra_cont_flush  = ra_control[28];
  assign ra_cont_tiley  = ra_control[13:8];
  assign ra_cont_tilex  = ra_control[7:2];

endmodule

// File: tb/tb_ra_list_walker.sv
// Bench for ra_list_walker: a latency-programmable VRAM responder checks every
// read against an address scoreboard; an entry monitor drives ready (with
// optional stalls) and checks every presented entry against an entry scoreboard.
module tb_ra_list_walker;
  localparam int AW = 24, MAXE = 4, CW = 11;

  logic          clock = 1'b0, reset_n = 1'b0;
  logic          ra_trig, fmt_v2, ra_vram_rd, ra_vram_dvalid;
  logic [AW-1:0] region_base, ra_vram_addr;
  logic [31:0]   ra_vram_din;
  logic [31:0]   ra_control, ra_opaque, ra_opaque_mod, ra_trans, ra_trans_mod, ra_puncht;
  logic          ra_cont_last, ra_cont_zclear, ra_cont_flush;
  logic [5:0]    ra_cont_tiley, ra_cont_tilex;
  logic          ra_entry_valid, ra_entry_ready, ra_busy, ra_done, ra_err;
  logic [CW-1:0] ra_entry_idx;

  ra_list_walker #(.ADDR_W(AW), .MAX_ENTRIES(MAXE), .CNT_W(CW)) dut (
    .clock(clock), .reset_n(reset_n), .ra_trig(ra_trig), .region_base(region_base),
    .fmt_v2(fmt_v2), .ra_vram_rd(ra_vram_rd), .ra_vram_addr(ra_vram_addr),
    .ra_vram_din(ra_vram_din), .ra_vram_dvalid(ra_vram_dvalid),
    .ra_control(ra_control), .ra_opaque(ra_opaque), .ra_opaque_mod(ra_opaque_mod),
    .ra_trans(ra_trans), .ra_trans_mod(ra_trans_mod), .ra_puncht(ra_puncht),
    .ra_cont_last(ra_cont_last), .ra_cont_zclear(ra_cont_zclear), .ra_cont_flush(ra_cont_flush),
    .ra_cont_tiley(ra_cont_tiley), .ra_cont_tilex(ra_cont_tilex),
    .ra_entry_valid(ra_entry_valid), .ra_entry_ready(ra_entry_ready),
    .ra_entry_idx(ra_entry_idx), .ra_busy(ra_busy), .ra_done(ra_done), .ra_err(ra_err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [5:0][31:0] w;
    logic [CW-1:0]    idx;
  } ent_t;

  logic [AW-1:0] exp_addr[$];
  ent_t          exp_ent[$];
  logic [31:0]   mem [logic [AW-1:0]];
  int            lat = 1, stall_idx = -1, stall_left = 0;
  int            n_chk = 0, n_pass = 0;
  bit            nxt_rd = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Build VRAM contents for a walk and push the expected reads and entries
  task automatic setup_walk(input logic [AW-1:0] base, input bit v2, input int n_ent, input bit last_on);
    logic [AW-1:0] a;
    ent_t e;
    int nw;
    a  = base & ~AW'(3);
    nw = v2 ? 6 : 5;
    for (int i = 0; i < n_ent; i++) begin
      e = '0;
      e.idx = CW'(i);
      for (int w = 0; w < nw; w++) begin
        if (w == 0)
          e.w[0] = ((last_on && i == n_ent - 1) ? 32'h8000_0000 : 32'h0)
                 | ((i % 2 == 1) ? 32'h4000_0000 : 32'h0)
                 | ((i == 2) ? 32'h1000_0000 : 32'h0)
                 | (32'(2 * i) << 8) | (32'(i) << 2);
        else
          e.w[w] = $urandom;
        mem[a] = e.w[w];
        exp_addr.push_back(a);
        a = a + AW'(4);
      end
      if (!v2) e.w[5] = 32'h8000_0000;
      exp_ent.push_back(e);
    end
  endtask

  task automatic trig(input logic [AW-1:0] base, input bit v2);
    @(negedge clock);
    region_base = base; fmt_v2 = v2; ra_trig = 1'b1;
    @(negedge clock);
    ra_trig = 1'b0;
    chk("rd_after_trig", 32'(ra_vram_rd), 32'd1);
    chk("busy_after_trig", 32'(ra_busy), 32'd1);
    chk("err_cleared", 32'(ra_err), 32'd0);
  endtask

  task automatic lat_first(input int nw);
    int n;
    n = 0;
    while (!ra_entry_valid && n < 1000) begin @(negedge clock); n++; end
    chk("first_valid_lat", 32'(n), 32'(nw * (lat + 1)));
  endtask

  task automatic wait_done(input bit exp_err, input int mid_at);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      ra_trig = (i == mid_at);
      if (ra_done) begin seen = 1'b1; break; end
    end
    ra_trig = 1'b0;
    chk("done_pulse", 32'(seen), 32'd1);
    chk("err_at_done", 32'(ra_err), 32'(exp_err));
    chk("busy_at_done", 32'(ra_busy), 32'd1);
    chk("reads_left", 32'(exp_addr.size()), 32'd0);
    chk("entries_left", 32'(exp_ent.size()), 32'd0);
  endtask

  task automatic post_idle();
    @(negedge clock);
    chk("busy_after_fin", 32'(ra_busy), 32'd0);
    chk("done_one_cycle", 32'(ra_done), 32'd0);
  endtask

  task automatic run(input logic [AW-1:0] base, input bit v2, input bit exp_err);
    trig(base, v2);
    lat_first(v2 ? 6 : 5);
    wait_done(exp_err, -1);
    post_idle();
  endtask

  // VRAM responder: answers each read after lat cycles, checks address order and hold
  initial begin
    logic [AW-1:0] a, ea;
    ra_vram_dvalid = 1'b0;
    ra_vram_din    = '0;
    @(negedge clock);
    forever begin
      if (!ra_vram_rd) @(negedge clock);
      else begin
        a = ra_vram_addr;
        if (exp_addr.size() == 0) begin
          chk("rd_extra", 32'(a), 32'hFFFF_FFFF);
          ea = a;
        end else begin
          ea = exp_addr.pop_front();
          chk("rd_addr", 32'(a), 32'(ea));
        end
        for (int k = 0; k < lat; k++) begin
          @(negedge clock);
          if (ra_busy) begin
            chk("rd_one_cycle", 32'(ra_vram_rd), 32'd0);
            chk("addr_hold", 32'(ra_vram_addr), 32'(ea));
          end
        end
        ra_vram_din    = mem.exists(a) ? mem[a] : 32'h0;
        ra_vram_dvalid = 1'b1;
        @(negedge clock);
        ra_vram_dvalid = 1'b0;
        ra_vram_din    = '0;
      end
    end
  end

  // Entry monitor: drives ready, compares every valid cycle against the scoreboard head
  initial begin
    ent_t e;
    bit   rdy;
    ra_entry_ready = 1'b0;
    forever begin
      @(negedge clock);
      if (nxt_rd) begin
        chk("rd_after_accept", 32'(ra_vram_rd), 32'd1);
        nxt_rd = 1'b0;
      end
      if (reset_n && ra_entry_valid) begin
        rdy = 1'b1;
        if (stall_left > 0 && int'(ra_entry_idx) == stall_idx) begin
          rdy = 1'b0;
          stall_left--;
        end
        ra_entry_ready = rdy;
        if (exp_ent.size() == 0) chk("entry_extra", 32'(ra_entry_idx), 32'hFFFF_FFFF);
        else begin
          e = exp_ent[0];
          chk("control", ra_control, e.w[0]);
          chk("opaque", ra_opaque, e.w[1]);
          chk("opaque_mod", ra_opaque_mod, e.w[2]);
          chk("trans", ra_trans, e.w[3]);
          chk("trans_mod", ra_trans_mod, e.w[4]);
          chk("puncht", ra_puncht, e.w[5]);
          chk("entry_idx", 32'(ra_entry_idx), 32'(e.idx));
          chk("cont_last", 32'(ra_cont_last), 32'(e.w[0][31]));
          chk("cont_zclear", 32'(ra_cont_zclear), 32'(e.w[0][30]));
          chk("cont_flush", 32'(ra_cont_flush), 32'(e.w[0][28]));
          chk("cont_tiley", 32'(ra_cont_tiley), 32'(e.w[0][13:8]));
          chk("cont_tilex", 32'(ra_cont_tilex), 32'(e.w[0][7:2]));
          if (rdy) begin
            void'(exp_ent.pop_front());
            nxt_rd = !e.w[0][31] && (e.idx != CW'(MAXE - 1));
          end
        end
      end else ra_entry_ready = 1'b0;
    end
  end

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, 32'(ra_busy), 32'd0);
    chk({tag, "_done"}, 32'(ra_done), 32'd0);
    chk({tag, "_err"}, 32'(ra_err), 32'd0);
    chk({tag, "_rd"}, 32'(ra_vram_rd), 32'd0);
    chk({tag, "_addr"}, 32'(ra_vram_addr), 32'd0);
    chk({tag, "_valid"}, 32'(ra_entry_valid), 32'd0);
    chk({tag, "_idx"}, 32'(ra_entry_idx), 32'd0);
    chk({tag, "_control"}, ra_control, 32'd0);
    chk({tag, "_puncht"}, ra_puncht, 32'd0);
  endtask

  initial begin
    ra_trig = 1'b0; region_base = '0; fmt_v2 = 1'b0;
    #1 chk_zero_outputs("reset");
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // v1 single entry, L=1
    lat = 1;
    setup_walk(24'h1667C0, 1'b0, 1, 1'b1);
    run(24'h1667C0, 1'b0, 1'b0);

    // v2 three entries, L=3, stall on entry 1, unaligned base
    lat = 3; stall_idx = 1; stall_left = 4;
    setup_walk(24'h1667C2, 1'b1, 3, 1'b1);
    run(24'h1667C2, 1'b1, 1'b0);
    stall_idx = -1;

    // Guard: LAST never set
    lat = 1;
    setup_walk(24'h200000, 1'b0, MAXE, 1'b0);
    run(24'h200000, 1'b0, 1'b1);
    // Next trigger clears the error
    setup_walk(24'h200100, 1'b1, 1, 1'b1);
    run(24'h200100, 1'b1, 1'b0);

    // Address wrap
    setup_walk(24'hFFFFF8, 1'b0, 1, 1'b1);
    run(24'hFFFFF8, 1'b0, 1'b0);

    // Triggers mid-walk and in the done cycle are ignored; one cycle later is accepted
    lat = 2;
    setup_walk(24'h300000, 1'b0, 2, 1'b1);
    trig(24'h300000, 1'b0);
    lat_first(5);
    wait_done(1'b0, 4);
    setup_walk(24'h300400, 1'b0, 1, 1'b1);
    region_base = 24'h300400; fmt_v2 = 1'b0; ra_trig = 1'b1;
    @(negedge clock);
    chk("fin_trig_ignored_rd", 32'(ra_vram_rd), 32'd0);
    chk("fin_trig_ignored_busy", 32'(ra_busy), 32'd0);
    @(negedge clock);
    ra_trig = 1'b0;
    chk("retrig_rd", 32'(ra_vram_rd), 32'd1);
    chk("retrig_busy", 32'(ra_busy), 32'd1);
    lat_first(5);
    wait_done(1'b0, -1);
    post_idle();

    // Reset during WAIT, late dvalid dropped, fresh walk
    lat = 3;
    setup_walk(24'h400000, 1'b0, 1, 1'b1);
    trig(24'h400000, 1'b0);
    @(negedge clock);
    chk("in_wait_rd", 32'(ra_vram_rd), 32'd0);
    reset_n = 1'b0;
    #1 chk_zero_outputs("midrst");
    exp_addr.delete();
    exp_ent.delete();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    chk("late_dvalid_busy", 32'(ra_busy), 32'd0);
    chk("late_dvalid_control", ra_control, 32'd0);
    chk("late_dvalid_valid", 32'(ra_entry_valid), 32'd0);
    lat = 1;
    setup_walk(24'h500000, 1'b1, 1, 1'b1);
    run(24'h500000, 1'b1, 1'b0);

    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
